// File: rtl/powlib_sfifo.sv
// rtl/powlib_sfifo.sv - single-clock first-word-fall-through FIFO
//
// Purpose: synchronous FIFO with registered occupancy count, almost-full flag
// and sticky overflow flag. The head entry is presented combinationally from
// the storage array, so a word written into an empty FIFO is visible on the
// next cycle.
//
// Ports:
//   clk     - clock, all state changes on posedge
//   rst     - synchronous active-high reset
//   wrdata  - write data (W bits)
//   wrvld   - write request
//   wrrdy   - FIFO can accept a write this cycle
//   rddata  - head-of-queue data, valid when rdvld=1
//   rdvld   - head entry present
//   rdrdy   - consumer accepts the head entry
//   count   - current occupancy, 0..D
//   afull   - count >= AFT
//   ovfl    - sticky: a write was presented while wrrdy=0
module powlib_sfifo #(
    parameter int W    = 16,
    parameter int D    = 8,
    parameter int AFT  = D - 1,
    parameter int WCNT = $clog2(D + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    wrdata,
    input  logic            wrvld,
    output logic            wrrdy,
    output logic [W-1:0]    rddata,
    output logic            rdvld,
    input  logic            rdrdy,
    output logic [WCNT-1:0] count,
    output logic            afull,
    output logic            ovfl
);

    localparam int              PW      = (D > 1) ? $clog2(D) : 1;
    localparam logic [WCNT-1:0] DEPTH   = WCNT'(D);
    localparam logic [WCNT-1:0] AFT_CNT = WCNT'(AFT);
    localparam logic [PW-1:0]   LAST    = PW'(D - 1);

    logic [W-1:0]    mem_q [D];
    logic [PW-1:0]   wrptr_q, wrptr_d;
    logic [PW-1:0]   rdptr_q, rdptr_d;
    logic [WCNT-1:0] count_q, count_d;
    logic            ovfl_q, ovfl_d;
    logic            wr_xfer;
    logic            rd_xfer;

    // Readiness comes only from registered state (and reset), never from
    // rdrdy: a full FIFO refuses a write even when a read retires the head.
    assign wrrdy   = !rst && (count_q < DEPTH);
    assign rdvld   = (count_q != '0);
    assign rddata  = mem_q[rdptr_q];
    assign count   = count_q;
    assign afull   = (count_q >= AFT_CNT);
    assign ovfl    = ovfl_q;

    assign wr_xfer = wrvld && wrrdy;
    assign rd_xfer = rdvld && rdrdy;

    always_comb begin
        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;
        count_d = count_q;
        ovfl_d  = ovfl_q;

        // Pointers wrap explicitly so D need not be a power of two.
        if (wr_xfer) begin
            wrptr_d = (wrptr_q == LAST) ? '0 : wrptr_q + PW'(1);
        end
        if (rd_xfer) begin
            rdptr_d = (rdptr_q == LAST) ? '0 : rdptr_q + PW'(1);
        end

        case ({wr_xfer, rd_xfer})
            2'b10:   count_d = count_q + WCNT'(1);
            2'b01:   count_d = count_q - WCNT'(1);
            default: count_d = count_q;
        endcase

        if (wrvld && !wrrdy) begin
            ovfl_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            count_q <= '0;
            ovfl_q  <= 1'b0;
        end else begin
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            count_q <= count_d;
            ovfl_q  <= ovfl_d;
        end
    end

    // Storage is deliberately not reset; stale contents are hidden by count.
    always_ff @(posedge clk) begin
        if (wr_xfer) begin
            mem_q[wrptr_q] <= wrdata;
        end
    end

endmodule

// File: tb/tb_powlib_sfifo.sv
// tb/tb_powlib_sfifo.sv - directed and random self-checking bench for powlib_sfifo
module tb_powlib_sfifo;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: W=8, D=4, AFT=3
    logic       rst;
    logic [7:0] wrdata;
    logic       wrvld;
    logic       wrrdy;
    logic [7:0] rddata;
    logic       rdvld;
    logic       rdrdy;
    logic [2:0] count;
    logic       afull;
    logic       ovfl;

    // Instance B: W=8, D=3, AFT=2
    logic       b_rst;
    logic [7:0] b_wrdata;
    logic       b_wrvld;
    logic       b_wrrdy;
    logic [7:0] b_rddata;
    logic       b_rdvld;
    logic       b_rdrdy;
    logic [1:0] b_count;
    logic       b_afull;
    logic       b_ovfl;

    int n_checks = 0;
    int n_fails  = 0;

    powlib_sfifo #(.W(8), .D(4), .AFT(3)) u_a (
        .clk(clk), .rst(rst), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
        .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy), .count(count),
        .afull(afull), .ovfl(ovfl)
    );

    powlib_sfifo #(.W(8), .D(3)) u_b (
        .clk(clk), .rst(b_rst), .wrdata(b_wrdata), .wrvld(b_wrvld), .wrrdy(b_wrrdy),
        .rddata(b_rddata), .rdvld(b_rdvld), .rdrdy(b_rdrdy), .count(b_count),
        .afull(b_afull), .ovfl(b_ovfl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst = 1'b1; wrvld = 1'b0; rdrdy = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic push_a(input logic [7:0] d);
        wrdata = d; wrvld = 1'b1;
        tick();
        wrvld = 1'b0;
    endtask

    task automatic pop_a(input string tag, input logic [7:0] d);
        chk({tag, "_vld"}, rdvld, 1'b1);
        chk({tag, "_data"}, rddata, d);
        rdrdy = 1'b1;
        tick();
        rdrdy = 1'b0;
    endtask

    logic [7:0] vec [4];
    logic [7:0] q [$];
    logic       m_ovfl;
    logic       m_wr;
    logic       m_rd;
    int         pw;

    initial begin
        vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33; vec[3] = 8'h44;
        rst = 1'b1; wrvld = 1'b0; rdrdy = 1'b0; wrdata = '0;
        b_rst = 1'b1; b_wrvld = 1'b0; b_rdrdy = 1'b0; b_wrdata = '0;
        tick();
        chk("rst_wrrdy_low", wrrdy, 1'b0);
        tick();
        rst = 1'b0; b_rst = 1'b0;
        #1;
        chk("rst_count", count, 3'd0);
        chk("rst_rdvld", rdvld, 1'b0);
        chk("rst_afull", afull, 1'b0);
        chk("rst_ovfl", ovfl, 1'b0);
        chk("rst_wrrdy", wrrdy, 1'b1);

        // Fill to full; afull from count 3
        for (int i = 0; i < 4; i++) begin
            wrdata = vec[i]; wrvld = 1'b1;
            tick();
            chk("fill_count", count, 32'(i + 1));
            chk("fill_afull", afull, (i + 1 >= 3) ? 1'b1 : 1'b0);
            chk("fill_wrrdy", wrrdy, (i < 3) ? 1'b1 : 1'b0);
        end
        wrvld = 1'b0;

        // Overflow attempt on a full FIFO
        wrdata = 8'h55; wrvld = 1'b1;
        tick();
        wrvld = 1'b0;
        chk("ovf_count", count, 3'd4);
        chk("ovf_flag", ovfl, 1'b1);
        tick();
        chk("ovf_sticky", ovfl, 1'b1);
        for (int i = 0; i < 4; i++) pop_a("ovf_drain", vec[i]);
        chk("drain_count", count, 3'd0);
        chk("drain_rdvld", rdvld, 1'b0);
        chk("drain_ovfl", ovfl, 1'b1);

        // Read of an empty FIFO is ignored
        rdrdy = 1'b1;
        tick();
        rdrdy = 1'b0;
        chk("empty_rd_count", count, 3'd0);
        chk("empty_rd_rdvld", rdvld, 1'b0);
        reset_a();
        chk("rst2_ovfl", ovfl, 1'b0);

        // Fall-through latency
        push_a(8'hA5);
        chk("fwft_vld", rdvld, 1'b1);
        chk("fwft_data", rddata, 8'hA5);
        rdrdy = 1'b1;
        tick();
        rdrdy = 1'b0;
        chk("fwft_empty", rdvld, 1'b0);

        // Simultaneous read/write at count=1
        push_a(8'h10);
        wrdata = 8'h20; wrvld = 1'b1; rdrdy = 1'b1;
        tick();
        wrvld = 1'b0; rdrdy = 1'b0;
        chk("rw1_vld", rdvld, 1'b1);
        chk("rw1_data", rddata, 8'h20);
        chk("rw1_count", count, 3'd1);
        pop_a("rw1_drain", 8'h20);

        // Simultaneous read/write at count=D: read proceeds, write refused
        for (int i = 1; i <= 4; i++) push_a(8'(i));
        wrdata = 8'h99; wrvld = 1'b1; rdrdy = 1'b1;
        tick();
        wrvld = 1'b0; rdrdy = 1'b0;
        chk("rwf_count", count, 3'd3);
        chk("rwf_ovfl", ovfl, 1'b1);
        for (int i = 2; i <= 4; i++) pop_a("rwf_drain", 8'(i));
        chk("rwf_empty", rdvld, 1'b0);
        reset_a();

        // Reset mid-operation discards contents
        push_a(8'h61);
        push_a(8'h62);
        chk("mid_count2", count, 3'd2);
        rst = 1'b1; wrdata = 8'hEE; wrvld = 1'b1; rdrdy = 1'b1;
        #1;
        chk("mid_rst_wrrdy", wrrdy, 1'b0);
        tick();
        rst = 1'b0; wrvld = 1'b0; rdrdy = 1'b0;
        #1;
        chk("mid_count", count, 3'd0);
        chk("mid_rdvld", rdvld, 1'b0);
        chk("mid_ovfl", ovfl, 1'b0);
        chk("mid_wrrdy", wrrdy, 1'b1);
        push_a(8'h77);
        chk("mid_count1", count, 3'd1);
        pop_a("mid_rd", 8'h77);
        chk("mid_empty", rdvld, 1'b0);

        // D=3 streaming with wraps
        b_wrdata = 8'd0; b_wrvld = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            b_wrdata = 8'(i + 1); b_wrvld = 1'b1; b_rdrdy = 1'b1;
            #1;
            chk("stream_count", b_count, 2'd1);
            chk("stream_data", b_rddata, 8'(i));
            tick();
        end
        b_wrvld = 1'b0; b_rdrdy = 1'b0;
        #1;
        chk("stream_last", b_rddata, 8'd10);
        chk("stream_ovfl", b_ovfl, 1'b0);

        // Random traffic against a queue model
        reset_a();
        q.delete();
        m_ovfl = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            pw = ((cyc / 500) % 2 == 0) ? 70 : 30;
            wrvld  = ($urandom_range(0, 99) < pw);
            rdrdy  = ($urandom_range(0, 99) >= pw);
            wrdata = 8'($urandom);
            #1;
            chk("rnd_count", count, 32'(q.size()));
            chk("rnd_rdvld", rdvld, (q.size() > 0) ? 1'b1 : 1'b0);
            chk("rnd_wrrdy", wrrdy, (q.size() < 4) ? 1'b1 : 1'b0);
            if (q.size() > 0) chk("rnd_data", rddata, q[0]);
            m_wr = wrvld && (q.size() < 4);
            m_rd = rdrdy && (q.size() > 0);
            if (wrvld && q.size() == 4) m_ovfl = 1'b1;
            if (m_rd) void'(q.pop_front());
            if (m_wr) q.push_back(wrdata);
            tick();
            chk("rnd_ovfl", ovfl, m_ovfl);
        end
        wrvld = 1'b0; rdrdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
